// File: rtl/lcmv_argmax_classifier_if.sv
// Score-in / class-out stream bundle for the LCMV argmax classifier.
// The slave modport is the classifier; the master modport is its environment.
interface lcmv_argmax_classifier_if #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 4
);
    logic [WIDTH-1:0]     axis_s_data;
    logic                 axis_s_valid;
    logic                 axis_s_last;
    logic                 axis_s_ready;
    logic [IDX_WIDTH-1:0] axis_c_class;
    logic [WIDTH-1:0]     axis_c_score;
    logic                 axis_c_valid;
    logic                 axis_c_last;
    logic                 axis_c_ready;

    modport slave (
        input  axis_s_data, axis_s_valid, axis_s_last, axis_c_ready,
        output axis_s_ready, axis_c_class, axis_c_score, axis_c_valid, axis_c_last
    );

    modport master (
        output axis_s_data, axis_s_valid, axis_s_last, axis_c_ready,
        input  axis_s_ready, axis_c_class, axis_c_score, axis_c_valid, axis_c_last
    );
endinterface

// File: rtl/lcmv_argmax_classifier.sv
// Per-pixel argmax over NUM_SIGNATURES binary32 scores, with a single result
// register, pixel counting, framing check and a sticky end-of-image flag.
module lcmv_argmax_classifier #(
    parameter int WIDTH          = 32,
    parameter int NUM_PIXELS     = 4096,
    parameter int NUM_SIGNATURES = 15,
    parameter int IDX_WIDTH      = $clog2(NUM_SIGNATURES)
) (
    input  logic                            clk,
    input  logic                            rst,
    lcmv_argmax_classifier_if.slave         bus,
    output logic                            framing_error,
    output logic                            finished
);
    localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_SIG = IDX_WIDTH'(NUM_SIGNATURES - 1);
    localparam logic [PIX_W-1:0]     LAST_PIX = PIX_W'(NUM_PIXELS - 1);
    localparam logic [WIDTH-1:0]     SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    // Monotonic unsigned key: -0 < +0, infinities at the ends, NaN pinned to 0.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] bits);
        logic is_nan;
        is_nan = (bits[30:23] == 8'hFF) && (bits[22:0] != 23'd0);
        if (is_nan)
            order_key = '0;
        else if (!bits[WIDTH-1])
            order_key = bits ^ SIGN_BIT;
        else
            order_key = ~bits;
    endfunction

    logic [IDX_WIDTH-1:0] sig_cnt_q, sig_cnt_d;
    logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [WIDTH-1:0]     best_key_q, best_key_d;
    logic [WIDTH-1:0]     best_bits_q, best_bits_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0] res_class_q, res_class_d;
    logic [WIDTH-1:0]     res_score_q, res_score_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_last_q, res_last_d;
    logic                 framing_q, framing_d;
    logic                 finished_q, finished_d;

    logic                 s_ready;
    logic                 accept;
    logic                 handoff;
    logic                 is_final;
    logic                 take;
    logic [WIDTH-1:0]     elem_key;
    logic [WIDTH-1:0]     win_key;
    logic [WIDTH-1:0]     win_bits;
    logic [IDX_WIDTH-1:0] win_idx;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        s_ready  = !rst && !finished_q && (!res_valid_q || bus.axis_c_ready);
        accept   = bus.axis_s_valid && s_ready;
        handoff  = res_valid_q && bus.axis_c_ready;
        is_final = (sig_cnt_q == LAST_SIG);
        elem_key = order_key(bus.axis_s_data);
        take     = (sig_cnt_q == '0) || (elem_key > best_key_q);
        win_key  = take ? elem_key         : best_key_q;
        win_bits = take ? bus.axis_s_data  : best_bits_q;
        win_idx  = take ? sig_cnt_q        : best_idx_q;
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        sig_cnt_d   = sig_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        best_key_d  = best_key_q;
        best_bits_d = best_bits_q;
        best_idx_d  = best_idx_q;
        res_class_d = res_class_q;
        res_score_d = res_score_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        framing_d   = 1'b0;
        finished_d  = finished_q;

        if (handoff) begin
            res_valid_d = 1'b0;
            if (res_last_q)
                finished_d = 1'b1;
        end

        if (accept) begin
            framing_d   = (bus.axis_s_last != is_final);
            best_key_d  = win_key;
            best_bits_d = win_bits;
            best_idx_d  = win_idx;
            if (is_final) begin
                // A same-cycle handoff is overridden here, keeping valid high.
                sig_cnt_d   = '0;
                res_class_d = win_idx;
                res_score_d = win_bits;
                res_valid_d = 1'b1;
                res_last_d  = (pix_cnt_q == LAST_PIX);
                pix_cnt_d   = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
            end else begin
                sig_cnt_d = sig_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the running-best registers are reset too, although element 0 always
    // overwrites them, so a reset mid-pixel leaves no stale state visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            best_key_q  <= '0;
            best_bits_q <= '0;
            best_idx_q  <= '0;
            res_class_q <= '0;
            res_score_q <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            framing_q   <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sig_cnt_q   <= sig_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            best_key_q  <= best_key_d;
            best_bits_q <= best_bits_d;
            best_idx_q  <= best_idx_d;
            res_class_q <= res_class_d;
            res_score_q <= res_score_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            framing_q   <= framing_d;
            finished_q  <= finished_d;
        end
    end

    assign bus.axis_s_ready = s_ready;
    assign bus.axis_c_class = res_class_q;
    assign bus.axis_c_score = res_score_q;
    assign bus.axis_c_valid = res_valid_q;
    assign bus.axis_c_last  = res_last_q;
    assign framing_error    = framing_q;
    assign finished         = finished_q;
endmodule

// File: tb/tb_lcmv_argmax_classifier.sv
// Randomized and directed bench for lcmv_argmax_classifier, scored against a
// float-ordering reference model (sign/magnitude comparison, NaN never wins).
module tb_lcmv_argmax_classifier;
    localparam int NS = 4;
    localparam int NP = 3;
    localparam int IW = 2;

    typedef struct {
        logic [31:0] data;
        bit          last;
        int          dir;
    } elem_t;

    typedef struct {
        logic [IW-1:0] cls;
        logic [31:0]   score;
        bit            last;
        int            dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic framing_error;
    logic finished;

    lcmv_argmax_classifier_if #(.WIDTH(32), .IDX_WIDTH(IW)) bus ();

    lcmv_argmax_classifier #(
        .WIDTH(32), .NUM_PIXELS(NP), .NUM_SIGNATURES(NS), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .framing_error(framing_error), .finished(finished)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    elem_t       stream[$];
    exp_t        sb[$];
    logic [31:0] cur[NS];
    int          msig, mpix;
    bit          fin_m, exp_fe;
    bit          rand_ready, rand_valid;
    int          stall_left;
    bit          stalled;
    logic [IW-1:0] held_cls;
    logic [31:0]   held_score;
    logic          held_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Real-number ordering of two non-NaN floats, with +0 above -0.
    function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int winner();
        int bi = 0;
        for (int i = 1; i < NS; i++)
            if (!is_nan(cur[i]) && (is_nan(cur[bi]) || gt(cur[i], cur[bi])))
                bi = i;
        return bi;
    endfunction

    task automatic push_pixel(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input int dir, input logic [3:0] lmask);
        logic [31:0] v[NS];
        elem_t e;
        v = '{a, b, c, d};
        for (int i = 0; i < NS; i++) begin
            e.data = v[i];
            e.last = lmask[i];
            e.dir  = (i == NS - 1) ? dir : -1;
            stream.push_back(e);
        end
    endtask

    task automatic clear_model();
        stream.delete();
        sb.delete();
        msig = 0; mpix = 0; fin_m = 0; exp_fe = 0; stalled = 0; stall_left = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.axis_s_valid = 1'b0; bus.axis_s_last = 1'b0; bus.axis_s_data = '0;
        bus.axis_c_ready = 1'b0;
        #1;
        check("rst_s_ready", 64'(bus.axis_s_ready), 64'd0);
        check("rst_c_valid", 64'(bus.axis_c_valid), 64'd0);
        check("rst_c_last",  64'(bus.axis_c_last),  64'd0);
        check("rst_c_class", 64'(bus.axis_c_class), 64'd0);
        check("rst_c_score", 64'(bus.axis_c_score), 64'd0);
        check("rst_framing", 64'(framing_error),    64'd0);
        check("rst_finished", 64'(finished),        64'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(bus.axis_s_ready), 64'd1);
    endtask

    task automatic step();
        exp_t  it;
        elem_t e;
        bit    c_hs, s_hs;
        @(negedge clk);
        check("framing_error", 64'(framing_error), 64'(exp_fe));
        exp_fe = 0;
        check("c_valid", 64'(bus.axis_c_valid), 64'(sb.size() != 0));
        check("finished", 64'(finished), 64'(fin_m));
        if (stalled) begin
            check("hold_class", 64'(bus.axis_c_class), 64'(held_cls));
            check("hold_score", 64'(bus.axis_c_score), 64'(held_score));
            check("hold_last",  64'(bus.axis_c_last),  64'(held_last));
        end

        if (stall_left > 0 && sb.size() != 0) begin
            bus.axis_c_ready = 1'b0;
            stall_left--;
        end else begin
            bus.axis_c_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (stream.size() != 0 && (!rand_valid || $urandom_range(4) != 0)) begin
            bus.axis_s_valid = 1'b1;
            bus.axis_s_data  = stream[0].data;
            bus.axis_s_last  = stream[0].last;
        end else begin
            bus.axis_s_valid = 1'b0;
            bus.axis_s_data  = $urandom;
            bus.axis_s_last  = 1'($urandom_range(1));
        end
        #1;
        check("s_ready", 64'(bus.axis_s_ready), 64'(!fin_m && (sb.size() == 0 || bus.axis_c_ready)));
        c_hs = bus.axis_c_valid && bus.axis_c_ready;
        s_hs = bus.axis_s_valid && bus.axis_s_ready;

        if (c_hs && sb.size() != 0) begin
            it = sb.pop_front();
            check("c_class", 64'(bus.axis_c_class), 64'(it.cls));
            check("c_score", 64'(bus.axis_c_score), 64'(it.score));
            check("c_last",  64'(bus.axis_c_last),  64'(it.last));
            if (it.dir >= 0)
                check("directed_class", 64'(bus.axis_c_class), 64'(it.dir));
            if (it.last) fin_m = 1;
        end
        stalled    = bus.axis_c_valid && !bus.axis_c_ready;
        held_cls   = bus.axis_c_class;
        held_score = bus.axis_c_score;
        held_last  = bus.axis_c_last;

        if (s_hs) begin
            e = stream.pop_front();
            cur[msig] = e.data;
            exp_fe = (e.last != (msig == NS - 1));
            if (msig == NS - 1) begin
                it.cls   = IW'(winner());
                it.score = cur[winner()];
                it.last  = (mpix == NP - 1);
                it.dir   = e.dir;
                sb.push_back(it);
                mpix = (mpix == NP - 1) ? 0 : mpix + 1;
                msig = 0;
            end else begin
                msig++;
            end
        end
    endtask

    task automatic run_phase(input int max_cycles);
        int n = 0;
        while (!((stream.size() == 0 || fin_m) && sb.size() == 0)) begin
            step();
            n++;
            if (n > max_cycles) begin
                check("timeout", 64'(n), 64'(max_cycles));
                break;
            end
        end
        repeat (3) step();
    endtask

    function automatic logic [31:0] gen_score(input logic [31:0] prev);
        logic [31:0] w = $urandom;
        case ($urandom_range(7))
            0: begin w[30:23] = 8'hFF; if (w[22:0] == 23'd0) w[0] = 1'b1; end
            1: w[30:0] = 31'h7F80_0000;
            2: w[30:0] = '0;
            3, 4: w = prev;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] s[NS];
        logic [3:0]  lm;
        bus.axis_s_valid = 1'b0; bus.axis_s_last = 1'b0; bus.axis_s_data = '0;
        bus.axis_c_ready = 1'b0;
        rand_ready = 0; rand_valid = 0;
        clear_model();

        // Winners, ties and signed zeros; full image ends with finished.
        do_reset();
        push_pixel(32'h3F80_0000, 32'h4060_0000, 32'hC000_0000, 32'h3F00_0000, 1, 4'b1000);
        push_pixel(32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 0, 4'b1000);
        push_pixel(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'hC0A0_0000, 1, 4'b1000);
        push_pixel(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, -1, 4'b1000);
        run_phase(200);

        // Negatives, NaN/inf, all-NaN, with a 10-cycle stall on the first result.
        do_reset();
        stall_left = 10;
        push_pixel(32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC080_0000, 1, 4'b1000);
        push_pixel(32'h7FC0_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2, 4'b1000);
        push_pixel(32'h7FC0_0000, 32'h7FC0_0001, 32'hFFC0_0000, 32'h7F80_0001, 0, 4'b1000);
        run_phase(200);

        // +inf first, then misframed pixels.
        do_reset();
        push_pixel(32'h7F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'hFF80_0000, 0, 4'b1000);
        push_pixel(32'h3F80_0000, 32'h4000_0000, 32'h4060_0000, 32'h3F00_0000, 2, 4'b0100);
        push_pixel(32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1, 4'b0000);
        run_phase(200);

        // Reset in the middle of a pixel, then a clean pixel from element 0.
        do_reset();
        push_pixel(32'h4110_0000, 32'h42C8_0000, 32'h3F80_0000, 32'h0000_0000, 1, 4'b1000);
        stream.push_back('{data: 32'h42C8_0000, last: 1'b0, dir: -1});
        stream.push_back('{data: 32'h4110_0000, last: 1'b0, dir: -1});
        run_phase(200);
        do_reset();
        push_pixel(32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h4000_0000, 3, 4'b1000);
        run_phase(200);

        // Random images with random handshakes and occasional framing faults.
        rand_ready = 1; rand_valid = 1;
        for (int img = 0; img < 30; img++) begin
            do_reset();
            for (int p = 0; p < NP; p++) begin
                s[0] = gen_score($urandom);
                for (int i = 1; i < NS; i++) s[i] = gen_score(s[$urandom_range(i - 1)]);
                lm = 4'b1000;
                if ($urandom_range(7) == 0) lm[$urandom_range(NS - 1)] ^= 1'b1;
                push_pixel(s[0], s[1], s[2], s[3], -1, lm);
            end
            if (img % 3 == 0) push_pixel($urandom, $urandom, $urandom, $urandom, -1, 4'b1000);
            run_phase(600);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcmv_argmax_classifier.md
# lcmv_argmax_classifier

Per-pixel argmax stage downstream of the LCMV filter-output multiply, which applies the weighting matrix produced by the weighting-matrix stage to each pixel. Consumes a stream of NUM_SIGNATURES IEEE-754 single-precision filter scores per pixel and emits, per pixel, the index of the winning signature plus its score. It counts pixels to mark the end of the image and raises `finished`.

## Interface
Parameters:
- `WIDTH`, 32: score width; IEEE-754 binary32 only.
- `NUM_PIXELS`, 4096: pixels per image.
- `NUM_SIGNATURES`, 15: scores per pixel (≥2).
- `IDX_WIDTH`, `$clog2(NUM_SIGNATURES)`: class index width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `axis_s_data` in WIDTH: score element.
- `axis_s_valid` in 1: score valid.
- `axis_s_last` in 1: producer's end-of-pixel marker.
- `axis_s_ready` out 1: score accepted when valid & ready.
- `axis_c_class` out IDX_WIDTH: winning signature index.
- `axis_c_score` out WIDTH: winning score bits, unmodified.
- `axis_c_valid` out 1: result valid.
- `axis_c_last` out 1: result belongs to pixel NUM_PIXELS-1.
- `axis_c_ready` in 1: result consumer ready.
- `framing_error` out 1: one-cycle pulse on a last/count mismatch.
- `finished` out 1: sticky; all NUM_PIXELS results handed off.

## Operation
- **Counters:** `sig_cnt` runs 0..NUM_SIGNATURES-1 and wraps on accept of element NUM_SIGNATURES-1. `pix_cnt` runs 0..NUM_PIXELS-1.
- **Running best:** registers `best_key` and `best_idx`. Element 0 of a pixel always loads them. A later element replaces them only if its key is strictly greater, so on ties the lowest index wins.
- **Ordering key** (unsigned compare):
  - sign=0: key = bits ^ 32'h8000_0000.
  - sign=1: key = ~bits.
  - Result: -0 < +0. Infinities order naturally.
- **NaN handling:** a NaN (exp=8'hFF, mantissa≠0) gets key 0 and is never a strict winner. If every element is NaN, the result is index 0 with element 0's bits.
- **Score output:** the original bits of the winner are stored alongside the key and output as `axis_c_score`.
- **End of pixel:** on accept of element NUM_SIGNATURES-1, the final compare includes that element. The result register loads and `axis_c_valid` rises. `axis_c_last` = (pix_cnt == NUM_PIXELS-1).
- **Single result register:** `axis_s_ready` = !finished & (!axis_c_valid | axis_c_ready). Accumulation stalls only when the result register is full and the final element is pending. Simplification: ready is held low for all elements while the result register is occupied and not being drained.
- **Framing check:** `framing_error` pulses for one cycle the cycle after an accept where axis_s_last ≠ (sig_cnt == NUM_SIGNATURES-1). The counter alone governs framing; data flow is unaffected.
- **End of image:** the handoff (valid & ready) of the last=1 result sets `finished`. After that `axis_s_ready` stays 0 until `rst`.
- **Reset mid-operation:** all partial pixels and any pending result are discarded, and the counters clear.

## Timing
- **Reset values:** axis_s_ready 0 during rst, then 1 the first cycle after release. axis_c_valid, axis_c_last, framing_error and finished are 0. axis_c_class and axis_c_score are 0.
- **Throughput:** one score per cycle; one pixel per NUM_SIGNATURES cycles with no bubbles when axis_c_ready = 1.
- **Latency:** the result is valid on the cycle after the final element is accepted.
- **Output stability:** axis_c_* holds stable while valid & !ready.
- **Simultaneous events:** a result handoff and a final-element accept in the same cycle reload the register and keep axis_c_valid = 1.

## Test plan
- **Basic winner:** NUM_SIGNATURES=4, scores {1.0, 3.5, -2.0, 0.5} → class 1, score 32'h4060_0000, valid 1 cycle after the 4th accept.
- **Ties and sign:**
  - {2.0, 2.0, -0.0, +0.0}, all below → class 0.
  - {-0.0, +0.0, -1.0, -5.0} → class 1.
  - All negative {-3, -1, -2, -4} → class 1.
- **NaN and infinity:**
  - {NaN 32'h7FC0_0000, -inf, 1.0, NaN} → class 2.
  - All NaN → class 0, score 32'h7FC0_0000.
  - {+inf, …} → class 0.
- **Backpressure:** hold axis_c_ready = 0 for 10 cycles with a result pending → outputs stable, axis_s_ready = 0, no data lost. Then ready = 1 with back-to-back pixels → full rate.
- **Framing:** assert axis_s_last on element 2 of 4 → one-cycle framing_error pulse, result still formed after 4 elements. Omit last on element 3 → pulse.
- **End of image and reset:**
  - NUM_PIXELS=3: axis_c_last only on the 3rd result. finished rises after its handoff, and axis_s_ready then stays 0.
  - Assert rst mid-pixel → outputs return to reset values, and the next pixel classifies correctly from element 0.
